srt4_div_frontend: RTL and testbench

//  Request front-end placed directly upstream of the unsigned radix-4 SRT divider.

---
 rtl/srt4_div_frontend_if.sv | 44 ++++
 rtl/srt4_div_frontend.sv | 150 +++++++++++++++
 tb/tb_srt4_div_frontend.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/srt4_div_frontend_if.sv
// Request, divider-side and result handshake signals of the SRT-4 divider front-end.
`default_nettype none

interface srt4_div_frontend_if #(
  parameter int WID = 8
);
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [WID-1:0] in_dividend;
  logic [WID-1:0] in_divisor;

  logic           div_valid;
  logic [WID-1:0] div_dividend;
  logic [WID-1:0] div_divisor;
  logic           div_ready;
  logic           div_error;
  logic [WID-1:0] div_quotient;
  logic [WID-1:0] div_remainder;

  logic           out_valid;
  logic           out_ready;
  logic [WID-1:0] out_quotient;
  logic [WID-1:0] out_remainder;
  logic           out_error;

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor,
    input  div_ready, div_error, div_quotient, div_remainder,
    input  out_ready,
    output in_ready, div_valid, div_dividend, div_divisor,
    output out_valid, out_quotient, out_remainder, out_error
  );

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor,
    output div_ready, div_error, div_quotient, div_remainder,
    output out_ready,
    input  in_ready, div_valid, div_dividend, div_divisor,
    input  out_valid, out_quotient, out_remainder, out_error
  );
endinterface

`default_nettype wire

// File: rtl/srt4_div_frontend.sv
// ============================================================================
// srt4_div_frontend : signed/unsigned request front-end for the radix-4 SRT divider
// Rev 1.0
// ============================================================================
`default_nettype none

module srt4_div_frontend #(
  parameter int WID     = 8,
  parameter int TIMEOUT = 2*WID + 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  srt4_div_frontend_if.slave   bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q;
  logic           in_ready_q;
  logic           div_valid_q;
  logic           out_valid_q;
  logic           out_error_q;
  logic [WID-1:0] div_dividend_q;
  logic [WID-1:0] div_divisor_q;
  logic [WID-1:0] out_quotient_q;
  logic [WID-1:0] out_remainder_q;
  logic [WID-1:0] dividend_q;
  logic           quo_neg_q;
  logic           rem_neg_q;
  logic [CW-1:0]  cnt_q;

  logic [WID-1:0] dvd_mag_d;
  logic [WID-1:0] dvs_mag_d;
  logic           quo_neg_d;
  logic           rem_neg_d;
  logic [WID-1:0] quo_fix_d;
  logic [WID-1:0] rem_fix_d;
  logic           abort_d;

  always_comb begin
    dvd_mag_d = bus.in_dividend;
    dvs_mag_d = bus.in_divisor;
    quo_neg_d = bus.in_signed & (bus.in_dividend[WID-1] ^ bus.in_divisor[WID-1]);
    rem_neg_d = bus.in_signed & bus.in_dividend[WID-1];
    if (bus.in_signed && bus.in_dividend[WID-1]) dvd_mag_d = ~bus.in_dividend + WID'(1);
    if (bus.in_signed && bus.in_divisor[WID-1])  dvs_mag_d = ~bus.in_divisor + WID'(1);

    quo_fix_d = quo_neg_q ? (~bus.div_quotient + WID'(1))  : bus.div_quotient;
    rem_fix_d = rem_neg_q ? (~bus.div_remainder + WID'(1)) : bus.div_remainder;

    // An error pulse outranks a coincident result pulse; the timeout only fires when idle.
    abort_d = bus.div_error | (~bus.div_ready & (cnt_q == CW'(TIMEOUT - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      in_ready_q      <= 1'b1;
      div_valid_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      out_error_q     <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
      dividend_q      <= '0;
      quo_neg_q       <= 1'b0;
      rem_neg_q       <= 1'b0;
      cnt_q           <= '0;
    end else begin
      div_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q     <= 1'b0;
            quo_neg_q      <= quo_neg_d;
            rem_neg_q      <= rem_neg_d;
            dividend_q     <= bus.in_dividend;
            div_dividend_q <= dvd_mag_d;
            div_divisor_q  <= dvs_mag_d;
            if (bus.in_divisor == '0) begin
              state_q         <= S_DONE;
              out_valid_q     <= 1'b1;
              out_error_q     <= 1'b1;
              out_quotient_q  <= '1;
              out_remainder_q <= bus.in_dividend;
            end else begin
              state_q     <= S_ISSUE;
              div_valid_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (abort_d) begin
            state_q         <= S_DONE;
            out_valid_q     <= 1'b1;
            out_error_q     <= 1'b1;
            out_quotient_q  <= '1;
            out_remainder_q <= dividend_q;
          end else if (bus.div_ready) begin
            state_q         <= S_DONE;
            out_valid_q     <= 1'b1;
            out_error_q     <= 1'b0;
            out_quotient_q  <= quo_fix_d;
            out_remainder_q <= rem_fix_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q         <= S_IDLE;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            out_error_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.div_valid     = div_valid_q;
  assign bus.div_dividend  = div_dividend_q;
  assign bus.div_divisor   = div_divisor_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_quotient  = out_quotient_q;
  assign bus.out_remainder = out_remainder_q;
  assign bus.out_error     = out_error_q;

endmodule

`default_nettype wire

// File: tb/tb_srt4_div_frontend.sv
// Bench for srt4_div_frontend: vector table, randomized requests against an
// arithmetic reference, divider model with selectable latency and failure modes.
`default_nettype none

module tb_srt4_div_frontend;

  localparam int WID     = 8;
  localparam int TIMEOUT = 2*WID + 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  srt4_div_frontend_if #(.WID(WID)) bus();

  srt4_div_frontend #(.WID(WID), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: 0 = normal, 1 = silent, 2 = error pulse, 3 = ready+error together
  int         mode;
  int         lat;
  int         dv_cnt;
  logic [7:0] seen_a;
  logic [7:0] seen_b;

  initial begin
    bus.div_ready     = 1'b0;
    bus.div_error     = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    dv_cnt = 0;
    seen_a = '0;
    seen_b = '0;
    forever begin
      @(negedge clk);
      if (bus.div_valid === 1'b1) begin
        dv_cnt++;
        seen_a = bus.div_dividend;
        seen_b = bus.div_divisor;
        if (mode != 1) begin
          @(posedge clk);
          repeat (lat) @(posedge clk);
          #1;
          bus.div_ready     = (mode == 0 || mode == 3);
          bus.div_error     = (mode == 2 || mode == 3);
          bus.div_quotient  = (seen_b != 0) ? seen_a / seen_b : 8'h00;
          bus.div_remainder = (seen_b != 0) ? seen_a % seen_b : 8'h00;
          @(posedge clk);
          #1;
          bus.div_ready = 1'b0;
          bus.div_error = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division (truncating, remainder follows dividend).
  function automatic void ref_div(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic e,
                                  output logic [7:0] ma, output logic [7:0] mb);
    int ia, ib;
    ia = sgn ? int'($signed(a)) : int'(a);
    ib = sgn ? int'($signed(b)) : int'(b);
    ma = 8'(ia < 0 ? -ia : ia);
    mb = 8'(ib < 0 ? -ib : ib);
    if (ib == 0) begin
      q = 8'hFF; r = a; e = 1'b1;
    end else begin
      q = 8'(ia / ib); r = 8'(ia % ib); e = 1'b0;
    end
  endfunction

  task automatic send(input logic sgn, input logic [7:0] a, input logic [7:0] b, output int acc);
    int n;
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_signed   = sgn;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) chk("accept_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_req(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ee,
                         input logic [7:0] ema, input logic [7:0] emb,
                         input int exp_lat, input int exp_pulses, input int hold);
    int acc, n, d0;
    d0 = dv_cnt;
    send(sgn, a, b, acc);
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", 32'(bus.out_valid), 32'(1));
    chk("latency", 32'(cyc - acc), 32'(exp_lat));
    chk("quotient", 32'(bus.out_quotient), 32'(eq));
    chk("remainder", 32'(bus.out_remainder), 32'(er));
    chk("error", 32'(bus.out_error), 32'(ee));
    chk("in_ready_busy", 32'(bus.in_ready), 32'(0));
    if (exp_pulses != 0) begin
      chk("div_dividend_mag", 32'(seen_a), 32'(ema));
      chk("div_divisor_mag", 32'(seen_b), 32'(emb));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.in_valid    = 1'b1;
      bus.in_signed   = 1'b0;
      bus.in_dividend = 8'h11;
      bus.in_divisor  = 8'h03;
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'(1));
      chk("hold_q", 32'(bus.out_quotient), 32'(eq));
      chk("hold_r", 32'(bus.out_remainder), 32'(er));
      chk("hold_in_ready", 32'(bus.in_ready), 32'(0));
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("exit_out_valid", 32'(bus.out_valid), 32'(0));
    chk("exit_in_ready", 32'(bus.in_ready), 32'(1));
    chk("exit_q_clear", 32'(bus.out_quotient), 32'(0));
    chk("div_valid_pulses", 32'(dv_cnt - d0), 32'(exp_pulses));
  endtask

  typedef struct {
    logic       sgn;
    logic [7:0] a, b, q, r;
    logic       e;
    logic [7:0] ma, mb;
    int         lat;
    int         hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q, r, ma, mb, a, b;
    logic       e, sgn;
    int         acc;

    vecs[0] = '{1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 8'h64, 8'h07, 3, 0};
    vecs[1] = '{1'b1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 1'b0, 8'h64, 8'h07, 0, 0};
    vecs[2] = '{1'b1, 8'h64,  8'hF9, 8'hF2, 8'h02, 1'b0, 8'h64, 8'h07, 5, 0};
    vecs[3] = '{1'b1, 8'h9C,  8'hF9, 8'h0E, 8'hFE, 1'b0, 8'h64, 8'h07, 1, 0};
    vecs[4] = '{1'b0, 8'h55,  8'h00, 8'hFF, 8'h55, 1'b1, 8'h00, 8'h00, 0, 0};
    vecs[5] = '{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 8'h80, 8'h01, 2, 5};

    n_checks = 0;
    n_errors = 0;
    mode = 0;
    lat  = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_signed = 1'b0;
    bus.in_dividend = '0; bus.in_divisor = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_div_valid", 32'(bus.div_valid), 32'(0));
    chk("rst_out_error", 32'(bus.out_error), 32'(0));
    chk("rst_out_q", 32'(bus.out_quotient), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      mode = 0;
      lat  = vecs[i].lat;
      run_req(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e,
              vecs[i].ma, vecs[i].mb, (vecs[i].b == 0) ? 0 : 2 + vecs[i].lat,
              (vecs[i].b == 0) ? 0 : 1, vecs[i].hold);
    end

    // Divider error, and error coinciding with a result: error must win.
    mode = 2; lat = 4;
    run_req(1'b1, 8'hC0, 8'h03, 8'hFF, 8'hC0, 1'b1, 8'h40, 8'h03, 6, 1, 0);
    mode = 3; lat = 2;
    run_req(1'b0, 8'h40, 8'h03, 8'hFF, 8'h40, 1'b1, 8'h40, 8'h03, 4, 1, 0);

    // Silent divider: abort after TIMEOUT cycles in WAIT.
    mode = 1;
    run_req(1'b0, 8'h2A, 8'h05, 8'hFF, 8'h2A, 1'b1, 8'h2A, 8'h05, 1 + TIMEOUT, 1, 0);

    // Asynchronous reset in the middle of WAIT.
    send(1'b0, 8'h33, 8'h04, acc);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("midwait_rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midwait_rst_div_valid", 32'(bus.div_valid), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      mode = 0;
      lat  = $urandom_range(0, 10);
      sgn  = 1'($urandom);
      a    = 8'($urandom);
      b    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ref_div(sgn, a, b, q, r, e, ma, mb);
      run_req(sgn, a, b, q, r, e, ma, mb, (b == 0) ? 0 : 2 + lat, (b == 0) ? 0 : 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
